control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 47 ++++
 rtl/control_sequencer.sv | 165 ++++++++++++++++
 tb/tb_control_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bundle of instruction input, memory handshake and datapath control strobes
// shared between the control sequencer and the datapath.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        mem_ready;

    logic        PCout;
    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        Zlowout;
    logic        Zhighout;
    logic        HIin;
    logic        LOin;

    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;

    logic [12:0] alu_sel;
    logic        run;
    logic [3:0]  state;

    // Sequencer side: consumes the instruction and memory status, drives strobes
    modport master (
        input  IR, mem_ready,
        output PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
               Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout,
               alu_sel, run, state
    );

    // Datapath side: supplies the instruction and memory status, obeys strobes
    modport slave (
        output IR, mem_ready,
        input  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin,
               Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout,
               alu_sel, run, state
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), opcode-dependent execute (T3-T6)
// and a HALTED sink that only a synchronous clear can leave.
module control_sequencer (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        T0     = 4'd0,
        T1     = 4'd1,
        T2     = 4'd2,
        T3     = 4'd3,
        T4     = 4'd4,
        T5     = 4'd5,
        T6     = 4'd6,
        HALTED = 4'd7
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [4:0]  opcode;
    logic        is_three_reg;
    logic        is_unary;
    logic        is_muldiv;
    logic        is_halt;
    logic [12:0] op_onehot;
    logic        unused_ir_bits;

    assign opcode         = bus.IR[31:27];
    assign unused_ir_bits = ^bus.IR[26:0];
    assign bus.state      = state_q;

    // Classify the opcode into an execution class and its one-hot ALU operation
    always_comb begin
        is_three_reg = 1'b0;
        is_unary     = 1'b0;
        is_muldiv    = 1'b0;
        is_halt      = 1'b0;
        op_onehot    = 13'd0;
        case (opcode)
            5'b00011: begin is_three_reg = 1'b1; op_onehot = 13'd1 << 0;  end
            5'b00100: begin is_three_reg = 1'b1; op_onehot = 13'd1 << 1;  end
            5'b00101: begin is_three_reg = 1'b1; op_onehot = 13'd1 << 2;  end
            5'b00110: begin is_three_reg = 1'b1; op_onehot = 13'd1 << 3;  end
            5'b00111: begin is_three_reg = 1'b1; op_onehot = 13'd1 << 7;  end
            5'b01000: begin is_three_reg = 1'b1; op_onehot = 13'd1 << 8;  end
            5'b01001: begin is_three_reg = 1'b1; op_onehot = 13'd1 << 4;  end
            5'b01010: begin is_three_reg = 1'b1; op_onehot = 13'd1 << 5;  end
            5'b01011: begin is_three_reg = 1'b1; op_onehot = 13'd1 << 6;  end
            5'b01111: begin is_muldiv    = 1'b1; op_onehot = 13'd1 << 11; end
            5'b10000: begin is_muldiv    = 1'b1; op_onehot = 13'd1 << 12; end
            5'b10001: begin is_unary     = 1'b1; op_onehot = 13'd1 << 9;  end
            5'b10010: begin is_unary     = 1'b1; op_onehot = 13'd1 << 10; end
            5'b11011: begin is_halt      = 1'b1;                          end
            default:  begin                                               end
        endcase
    end

    // State register; clear overrides every transition including HALTED
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= T0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; T1 waits for memory, execute length follows the opcode class
    always_comb begin
        state_d = T0;
        case (state_q)
            T0:      state_d = T1;
            T1:      state_d = bus.mem_ready ? T2 : T1;
            T2:      state_d = T3;
            T3: begin
                if (is_three_reg || is_unary || is_muldiv) begin
                    state_d = T4;
                end else if (is_halt) begin
                    state_d = HALTED;
                end else begin
                    state_d = T0;
                end
            end
            T4:      state_d = (is_three_reg || is_muldiv) ? T5 : T0;
            T5:      state_d = is_muldiv ? T6 : T0;
            T6:      state_d = T0;
            HALTED:  state_d = HALTED;
            default: state_d = T0;
        endcase
    end

    // Strobe decode from state and opcode; everything is held low during clear
    always_comb begin
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.MARin    = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.alu_sel  = 13'd0;
        bus.run      = 1'b0;
        if (!clear) begin
            bus.run = (state_q != HALTED);
            case (state_q)
                T0: begin
                    bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                end
                T1: begin
                    bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                end
                T2: begin
                    bus.MDRout = 1'b1; bus.IRin = 1'b1;
                end
                T3: begin
                    if (is_three_reg) begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end else if (is_unary) begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_sel = op_onehot;
                    end else if (is_muldiv) begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end
                end
                T4: begin
                    if (is_three_reg) begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_sel = op_onehot;
                    end else if (is_unary) begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end else if (is_muldiv) begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_sel = op_onehot;
                    end
                end
                T5: begin
                    if (is_three_reg) begin
                        bus.Gra = 1'b1; bus.Rin = 1'b1; bus.Zlowout = 1'b1;
                    end else if (is_muldiv) begin
                        bus.Zlowout = 1'b1; bus.LOin = 1'b1;
                    end
                end
                T6: begin
                    if (is_muldiv) begin
                        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle queues the
// hand-computed expected outputs, a negedge monitor pops and compares.
module tb_control_sequencer;

    localparam logic [18:0] PCOUT    = 19'd1 << 18;
    localparam logic [18:0] PCIN     = 19'd1 << 17;
    localparam logic [18:0] INCPC    = 19'd1 << 16;
    localparam logic [18:0] MARIN    = 19'd1 << 15;
    localparam logic [18:0] READ     = 19'd1 << 14;
    localparam logic [18:0] MDRIN    = 19'd1 << 13;
    localparam logic [18:0] MDROUT   = 19'd1 << 12;
    localparam logic [18:0] IRIN     = 19'd1 << 11;
    localparam logic [18:0] YIN      = 19'd1 << 10;
    localparam logic [18:0] ZIN      = 19'd1 << 9;
    localparam logic [18:0] ZLOWOUT  = 19'd1 << 8;
    localparam logic [18:0] ZHIGHOUT = 19'd1 << 7;
    localparam logic [18:0] HIIN     = 19'd1 << 6;
    localparam logic [18:0] LOIN     = 19'd1 << 5;
    localparam logic [18:0] GRA      = 19'd1 << 4;
    localparam logic [18:0] GRB      = 19'd1 << 3;
    localparam logic [18:0] GRC      = 19'd1 << 2;
    localparam logic [18:0] RIN      = 19'd1 << 1;
    localparam logic [18:0] ROUT     = 19'd1 << 0;

    localparam logic [18:0] E_T0   = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [18:0] E_T1   = ZLOWOUT | PCIN | READ | MDRIN;
    localparam logic [18:0] E_T2   = MDROUT | IRIN;
    localparam logic [18:0] E_NONE = 19'd0;

    typedef struct {
        logic [3:0]  st;
        logic [18:0] strb;
        logic        run;
        logic [12:0] alu;
        string       name;
    } exp_t;

    logic   clock = 1'b0;
    logic   clear = 1'b1;
    exp_t   scoreboard[$];
    int     checks = 0;
    int     errors = 0;
    logic   stim_done = 1'b0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs just after the rising edge and queue what that cycle must show
    task automatic applyStimulus(input logic clr, input logic [31:0] ir, input logic mr,
                                 input logic [3:0] st, input logic [18:0] strb,
                                 input logic [12:0] alu, input string nm);
        exp_t e;
        @(posedge clock);
        #1;
        clear         = clr;
        bus.IR        = ir;
        bus.mem_ready = mr;
        e.st   = st;
        e.strb = clr ? E_NONE : strb;
        e.run  = !clr && (st != 4'd7);
        e.alu  = clr ? 13'd0 : alu;
        e.name = nm;
        scoreboard.push_back(e);
    endtask

    // Compare the sampled outputs of this cycle against one scoreboard entry
    task automatic checkOutput(input exp_t e);
        logic [18:0] act_strb;
        act_strb = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.Read, bus.MDRin,
                    bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Zhighout,
                    bus.HIin, bus.LOin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout};
        checks++;
        if (bus.state !== e.st || act_strb !== e.strb || bus.run !== e.run || bus.alu_sel !== e.alu) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d strb=%05h run=%b alu=%04h, expected state=%0d strb=%05h run=%b alu=%04h",
                     e.name, bus.state, act_strb, bus.run, bus.alu_sel, e.st, e.strb, e.run, e.alu);
        end
    endtask

    // Monitor: every falling edge with a pending expectation gets compared
    initial begin
        forever begin
            @(negedge clock);
            if (scoreboard.size() != 0) begin
                checkOutput(scoreboard.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] ir;
        bus.IR        = 32'd0;
        bus.mem_ready = 1'b1;

        // Reset and first cycle after release
        applyStimulus(1'b1, 32'd0, 1'b1, 4'd0, E_NONE, 13'd0, "reset");
        ir = 32'h4B820000;
        applyStimulus(1'b0, ir, 1'b1, 4'd0, E_T0, 13'd0, "shr_t0_after_clear");
        applyStimulus(1'b0, ir, 1'b1, 4'd1, E_T1, 13'd0, "shr_t1");
        applyStimulus(1'b0, ir, 1'b1, 4'd2, E_T2, 13'd0, "shr_t2");
        applyStimulus(1'b0, ir, 1'b1, 4'd3, GRB | ROUT | YIN, 13'd0, "shr_t3");
        applyStimulus(1'b0, ir, 1'b1, 4'd4, GRC | ROUT | ZIN, 13'h0010, "shr_t4");
        applyStimulus(1'b0, ir, 1'b1, 4'd5, GRA | RIN | ZLOWOUT, 13'd0, "shr_t5");

        // MUL R3,R1
        ir = 32'h79880000;
        applyStimulus(1'b0, ir, 1'b1, 4'd0, E_T0, 13'd0, "mul_t0");
        applyStimulus(1'b0, ir, 1'b1, 4'd1, E_T1, 13'd0, "mul_t1");
        applyStimulus(1'b0, ir, 1'b1, 4'd2, E_T2, 13'd0, "mul_t2");
        applyStimulus(1'b0, ir, 1'b1, 4'd3, GRA | ROUT | YIN, 13'd0, "mul_t3");
        applyStimulus(1'b0, ir, 1'b1, 4'd4, GRB | ROUT | ZIN, 13'h0800, "mul_t4");
        applyStimulus(1'b0, ir, 1'b1, 4'd5, ZLOWOUT | LOIN, 13'd0, "mul_t5");
        applyStimulus(1'b0, ir, 1'b1, 4'd6, ZHIGHOUT | HIIN, 13'd0, "mul_t6");

        // NEG R2,R5 with a three-cycle memory stall in T1
        ir = 32'h89280000;
        applyStimulus(1'b0, ir, 1'b0, 4'd0, E_T0, 13'd0, "neg_t0");
        applyStimulus(1'b0, ir, 1'b0, 4'd1, E_T1, 13'd0, "neg_t1_stall1");
        applyStimulus(1'b0, ir, 1'b0, 4'd1, E_T1, 13'd0, "neg_t1_stall2");
        applyStimulus(1'b0, ir, 1'b0, 4'd1, E_T1, 13'd0, "neg_t1_stall3");
        applyStimulus(1'b0, ir, 1'b1, 4'd1, E_T1, 13'd0, "neg_t1_ready");
        applyStimulus(1'b0, ir, 1'b1, 4'd2, E_T2, 13'd0, "neg_t2");
        applyStimulus(1'b0, ir, 1'b1, 4'd3, GRB | ROUT | ZIN, 13'h0200, "neg_t3");
        applyStimulus(1'b0, ir, 1'b1, 4'd4, ZLOWOUT | GRA | RIN, 13'd0, "neg_t4");

        // NOP, then an undefined opcode
        ir = 32'hD0000000;
        applyStimulus(1'b0, ir, 1'b1, 4'd0, E_T0, 13'd0, "nop_t0");
        applyStimulus(1'b0, ir, 1'b1, 4'd1, E_T1, 13'd0, "nop_t1");
        applyStimulus(1'b0, ir, 1'b1, 4'd2, E_T2, 13'd0, "nop_t2");
        applyStimulus(1'b0, ir, 1'b1, 4'd3, E_NONE, 13'd0, "nop_t3");
        ir = 32'hF8000000;
        applyStimulus(1'b0, ir, 1'b1, 4'd0, E_T0, 13'd0, "undef_t0");
        applyStimulus(1'b0, ir, 1'b1, 4'd1, E_T1, 13'd0, "undef_t1");
        applyStimulus(1'b0, ir, 1'b1, 4'd2, E_T2, 13'd0, "undef_t2");
        applyStimulus(1'b0, ir, 1'b1, 4'd3, E_NONE, 13'd0, "undef_t3");

        // ADD interrupted by clear in T4
        ir = 32'h19A18000;
        applyStimulus(1'b0, ir, 1'b1, 4'd0, E_T0, 13'd0, "add_t0");
        applyStimulus(1'b0, ir, 1'b1, 4'd1, E_T1, 13'd0, "add_t1");
        applyStimulus(1'b0, ir, 1'b1, 4'd2, E_T2, 13'd0, "add_t2");
        applyStimulus(1'b0, ir, 1'b1, 4'd3, GRB | ROUT | YIN, 13'd0, "add_t3");
        applyStimulus(1'b1, ir, 1'b1, 4'd4, E_NONE, 13'd0, "add_t4_clear");

        // HALT: decode, then sit in HALTED until a clear pulse
        ir = 32'hD8000000;
        applyStimulus(1'b0, ir, 1'b1, 4'd0, E_T0, 13'd0, "halt_t0_after_clear");
        applyStimulus(1'b0, ir, 1'b1, 4'd1, E_T1, 13'd0, "halt_t1");
        applyStimulus(1'b0, ir, 1'b1, 4'd2, E_T2, 13'd0, "halt_t2");
        applyStimulus(1'b0, ir, 1'b1, 4'd3, E_NONE, 13'd0, "halt_t3");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, ir, i[0], 4'd7, E_NONE, 13'd0, "halted_hold");
        end
        applyStimulus(1'b1, ir, 1'b1, 4'd7, E_NONE, 13'd0, "halted_clear");
        applyStimulus(1'b0, ir, 1'b1, 4'd0, E_T0, 13'd0, "restart_t0");
        applyStimulus(1'b0, ir, 1'b1, 4'd1, E_T1, 13'd0, "restart_t1");

        stim_done = 1'b1;
    end

    // Wait for the stimulus to drain, then confirm every expectation was consumed
    initial begin
        int budget;
        budget = 0;
        while (!stim_done && budget < 2000) begin
            @(negedge clock);
            budget++;
        end
        @(negedge clock);
        #1;
        checks++;
        if (!stim_done || scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: stim_done=%b pending=%0d, expected stim_done=1 pending=0",
                     stim_done, scoreboard.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
